fir_coeff_ctrl: RTL and testbench
=================================

// Module: fir_coeff_ctrl
// PURPOSE
//  Double-buffered coefficient controller for the FIR filter. Accepts coefficient writes over a
//  valid/ready config port into a shadow bank, then swaps shadow->active atomically on a sample
//  boundary so each FIR output uses exactly one coefficient set. Drives the FIR's coefficient input.
// PARAMETERS
//  FILTER_BITS   12                     coefficient width
//  FILTER_TAPS   64                     number of taps / coefficients per bank
//  ADDR_BITS     $clog2(FILTER_TAPS)    cfg address width
// PORTS
//  clk                  in   1            system clock
//  rst_n                in   1            asynchronous reset, active-low
//  cfg_valid            in   1            config word valid
//  cfg_ready            out  1            config word accepted when valid&ready
//  cfg_addr             in   ADDR_BITS    tap index for cfg_data
//  cfg_data             in   FILTER_BITS  coefficient value
//  cfg_last             in   1            with accepted word: final word, arm swap
//  cfg_abort            in   1            discard pending load, return to IDLE
//  sample_strobe        in   1            FIR data_in_ready (sample boundary)
//  coeff_out[TAPS]      out  FILTER_BITS  active bank, feeds FIR filter_coefficients
//  swap_pending         out  1            shadow armed, waiting for sample_strobe
//  swap_done            out  1            1-cycle pulse on the cycle after swap
//  cfg_err              out  1            sticky: out-of-range address seen; cleared by cfg_abort
// BEHAVIOUR
//  - Reset: both banks all-zero, state IDLE, cfg_ready=1, swap_pending=0, swap_done=0, cfg_err=0.
//  - States: IDLE -> LOAD on first accepted word (without cfg_last); IDLE/LOAD -> ARMED on accepted
//    word with cfg_last; ARMED -> IDLE at swap; any -> IDLE on cfg_abort.
//  - cfg_ready = 1 in IDLE/LOAD, 0 in ARMED (shadow frozen while armed).
//  - Accepted word writes shadow[cfg_addr] at that edge; 0-cycle write latency.
//  - cfg_addr >= FILTER_TAPS: write dropped, cfg_err set, cfg_last still honoured.
//  - Swap: in ARMED, at the edge where sample_strobe=1, active <= shadow (all taps, one edge);
//    shadow retains contents (next load edits a copy of the set now active). swap_done high next cycle.
//    The FIR multiplies the sample shifted in at that edge with the new set: no mixed-set outputs.
//  - cfg_last accepted and sample_strobe in the same cycle: no swap that cycle; swap at next strobe.
//  - cfg_abort wins over cfg_valid and sample_strobe in the same cycle; the shadow is reloaded from
//    active (abandoned edits discarded), active is unchanged, cfg_err cleared.
//  - Words unaccepted (cfg_ready=0) have no effect; no sample_strobe in ARMED -> wait indefinitely.
//  - Reset asserted mid-load or while armed: immediate return to reset state, both banks cleared.
// CONFIGURATION
//  FIR_COEFF_READBACK_EN defined: adds ports rd_addr (in, ADDR_BITS) and rd_data (out, FILTER_BITS);
//    rd_data = active[rd_addr] registered, 1-cycle latency, 0 for out-of-range addr, reset 0.
//  Not defined: ports absent, no readback logic.
// STRUCTURE
//  - fir_pkg: typedef coeff_t (logic [FILTER_BITS-1:0]), enum coeff_state_t {IDLE, LOAD, ARMED}.
//  - Sub-module coeff_bank: FILTER_TAPS register array with write port, bulk load, async clear;
//    instantiated twice (shadow, active). Controller FSM + error flag in top.
// TESTING
//  1 Reset -> coeff_out all 0, cfg_ready=1, swap_pending=0, cfg_err=0.
//  2 Write taps 0..63 = tap index, last on 63; strobe 5 cycles later -> coeff_out unchanged until that
//    edge, then coeff_out[i]=i, swap_done pulse 1 cycle, cfg_ready back to 1.
//  3 cfg_last accepted same cycle as sample_strobe -> no swap; swap on next strobe only.
//  4 Armed, cfg_valid held with addr 3 data 0x7FF -> not accepted; after swap, accepted into shadow only.
//  5 Write addr 70 (TAPS=64 with ADDR_BITS=7 variant, TAPS=65) -> cfg_err=1, shadow unchanged; cfg_abort
//    -> cfg_err=0, state IDLE, active unchanged.
//  6 Partial load then rst_n low mid-load -> both banks 0, IDLE; with FIR_COEFF_READBACK_EN,
//    rd_addr=5 after load+swap of value 0x123 -> rd_data=0x123 one cycle later.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared coefficient type, controller states and default sizes for the FIR coefficient controller.
package fir_pkg;
  localparam int FIR_BITS = 12;
  localparam int FIR_TAPS = 64;
  typedef logic [FIR_BITS-1:0] coeff_t;
  typedef enum logic [1:0] {IDLE, LOAD, ARMED} coeff_state_t;
endpackage

// File: rtl/coeff_bank.sv
// coeff_bank: TAPS-deep coefficient register array with a single write port, whole-bank load and async clear.
module coeff_bank
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  coeff_t        i_wdata,
  input  logic          i_load,
  input  coeff_t        i_load_data [TAPS],
  output coeff_t        o_data [TAPS]
);
  coeff_t r_mem [TAPS];
  // bulk load takes precedence so a swap or abort never merges with a stray write
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < TAPS; i++) r_mem[i] <= '0;
    else if (i_load)
      r_mem <= i_load_data;
    else if (i_we)
      r_mem[i_waddr] <= i_wdata;
  assign o_data = r_mem;
endmodule

// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: double-buffered FIR coefficient controller; config writes fill a shadow bank that swaps into
// the active bank on a sample boundary. Optional readback port enabled by FIR_COEFF_READBACK_EN.
module fir_coeff_ctrl
  import fir_pkg::*;
#(
  parameter int FILTER_TAPS = FIR_TAPS,
  parameter int ADDR_BITS   = $clog2(FILTER_TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cfg_valid,
  output logic                 o_cfg_ready,
  input  logic [ADDR_BITS-1:0] i_cfg_addr,
  input  coeff_t               i_cfg_data,
  input  logic                 i_cfg_last,
  input  logic                 i_cfg_abort,
  input  logic                 i_sample_strobe,
  output coeff_t               o_coeff_out [FILTER_TAPS],
  output logic                 o_swap_pending,
  output logic                 o_swap_done,
  output logic                 o_cfg_err
`ifdef FIR_COEFF_READBACK_EN
  ,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output coeff_t               o_rd_data
`endif
);
  localparam int IW = $clog2(FILTER_TAPS);
  coeff_state_t r_state, w_next_state;
  logic   w_accept, w_in_range, w_swap, r_swap_done, r_cfg_err;
  coeff_t w_shadow [FILTER_TAPS];
  coeff_t w_active [FILTER_TAPS];
  assign w_accept   = i_cfg_valid & o_cfg_ready & ~i_cfg_abort;
  assign w_in_range = {1'b0, i_cfg_addr} < (ADDR_BITS+1)'(FILTER_TAPS);
  assign w_swap     = (r_state == ARMED) & i_sample_strobe & ~i_cfg_abort;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  always_comb
    w_next_state = i_cfg_abort         ? IDLE :
                   (r_state == ARMED)  ? (i_sample_strobe ? IDLE : ARMED) :
                   w_accept            ? (i_cfg_last ? ARMED : LOAD) :
                   r_state;
  always_comb begin
    o_cfg_ready    = r_state != ARMED;
    o_swap_pending = r_state == ARMED;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_swap_done <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_swap_done <= w_swap;
      r_cfg_err   <= i_cfg_abort ? 1'b0 : (r_cfg_err | (w_accept & ~w_in_range));
    end
  assign o_swap_done = r_swap_done;
  assign o_cfg_err   = r_cfg_err;
  // abort restores the shadow from the active set so abandoned edits vanish
  coeff_bank #(.TAPS(FILTER_TAPS), .AW(IW)) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (w_accept & w_in_range),
    .i_waddr     (i_cfg_addr[IW-1:0]),
    .i_wdata     (i_cfg_data),
    .i_load      (i_cfg_abort),
    .i_load_data (w_active),
    .o_data      (w_shadow)
  );
  coeff_bank #(.TAPS(FILTER_TAPS), .AW(IW)) u_active (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (1'b0),
    .i_waddr     ('0),
    .i_wdata     ('0),
    .i_load      (w_swap),
    .i_load_data (w_shadow),
    .o_data      (w_active)
  );
  assign o_coeff_out = w_active;
`ifdef FIR_COEFF_READBACK_EN
  coeff_t r_rd_data;
  logic   w_rd_ok;
  assign w_rd_ok = {1'b0, i_rd_addr} < (ADDR_BITS+1)'(FILTER_TAPS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= w_rd_ok ? w_active[i_rd_addr[IW-1:0]] : '0;
  assign o_rd_data = r_rd_data;
`endif
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl: scoreboard bench; a reference model predicts each swapped coefficient set, a monitor checks it on swap_done.
module tb_fir_coeff_ctrl;
  import fir_pkg::*;
  localparam int TAPS = 64;
  localparam int AB   = 7;
  typedef logic [TAPS-1:0][11:0] bank_t;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0, cfg_last = 1'b0, cfg_abort = 1'b0, sample_strobe = 1'b0;
  logic [AB-1:0] cfg_addr = '0;
  coeff_t        cfg_data = '0;
  logic          cfg_ready, swap_pending, swap_done, cfg_err;
  coeff_t        coeff_out [TAPS];
`ifdef FIR_COEFF_READBACK_EN
  logic [AB-1:0] rd_addr = '0;
  coeff_t        rd_data;
  logic [11:0]   exp_rd;
`endif
  int    checks = 0, errors = 0;
  bank_t m_shadow = '0, m_active = '0;
  bank_t exp_q[$];
  int    m_st = 0;
  bit    m_err = 1'b0;
  fir_coeff_ctrl #(.FILTER_TAPS(TAPS), .ADDR_BITS(AB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_cfg_valid    (cfg_valid),
    .o_cfg_ready    (cfg_ready),
    .i_cfg_addr     (cfg_addr),
    .i_cfg_data     (cfg_data),
    .i_cfg_last     (cfg_last),
    .i_cfg_abort    (cfg_abort),
    .i_sample_strobe(sample_strobe),
    .o_coeff_out    (coeff_out),
    .o_swap_pending (swap_pending),
    .o_swap_done    (swap_done),
    .o_cfg_err      (cfg_err)
`ifdef FIR_COEFF_READBACK_EN
    ,
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data)
`endif
  );
  always #5 clk = ~clk;
  function automatic bank_t pack_out();
    bank_t b;
    for (int i = 0; i < TAPS; i++) b[i] = coeff_out[i];
    return b;
  endfunction
  task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n && swap_done) begin
      if (exp_q.size() == 0) chk("swap_done_unexpected", 1, 0);
      else chk("swapped_set", pack_out(), exp_q.pop_front());
    end
  task automatic cyc(input bit v, input int a, input int d, input bit l, input bit ab, input bit s);
    bit rdy;
    cfg_valid = v; cfg_addr = a[AB-1:0]; cfg_data = d[11:0];
    cfg_last = l; cfg_abort = ab; sample_strobe = s;
`ifdef FIR_COEFF_READBACK_EN
    rd_addr = AB'($urandom_range(0, 79));
    exp_rd  = (int'(rd_addr) < TAPS) ? m_active[rd_addr] : 12'h0;
`endif
    rdy = (m_st != 2);
    if (ab) begin
      m_shadow = m_active; m_err = 1'b0; m_st = 0;
    end else if (v && rdy) begin
      if (a < TAPS) m_shadow[a] = d[11:0];
      else m_err = 1'b1;
      if (l) m_st = 2;
      else if (m_st == 0) m_st = 1;
    end else if (m_st == 2 && s) begin
      m_active = m_shadow;
      exp_q.push_back(m_active);
      m_st = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("cfg_ready", cfg_ready, m_st != 2);
    chk("swap_pending", swap_pending, m_st == 2);
    chk("cfg_err", cfg_err, m_err);
    chk("coeff_out", pack_out(), m_active);
`ifdef FIR_COEFF_READBACK_EN
    chk("rd_data", rd_data, exp_rd);
`endif
  endtask
  task automatic check_reset_state();
    chk("rst_coeff_out", pack_out(), 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_swap_done", swap_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
`ifdef FIR_COEFF_READBACK_EN
    chk("rst_rd_data", rd_data, 0);
`endif
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_state();
    m_shadow = '0; m_active = '0; m_st = 0; m_err = 1'b0;
    exp_q.delete();
    cfg_valid = 1'b0; cfg_abort = 1'b0; sample_strobe = 1'b0; cfg_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;
    for (int i = 0; i < TAPS; i++) cyc(1, i, i, i == TAPS - 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 'h55, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 'h11, 1, 0, 0);
    repeat (2) cyc(1, 3, 'h7FF, 0, 0, 0);
    cyc(1, 3, 'h7FF, 0, 0, 1);
    cyc(1, 3, 'h7FF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 70, 'hABC, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 70, 'hABC, 0, 1, 1);
    cyc(1, 9, 'h123, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 10, 'h321, 0, 0, 0);
    cyc(1, 11, 'h222, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      int a;
      a = ($urandom_range(0, 15) == 0) ? $urandom_range(TAPS, 127) : $urandom_range(0, TAPS - 1);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc($urandom_range(0, 1) == 1, a, $urandom_range(0, 4095), $urandom_range(0, 19) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0);
    end
    repeat (3) cyc(0, 0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
